// File: rtl/prog_loader.sv
// Program loader: parses a byte-stream frame (sync, address, count, 14-bit
// words, checksum) into single-cycle instruction-memory writes and holds the
// core in reset until a frame with a good checksum has been fully loaded.
module prog_loader #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 14,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle, StAddrH, StAddrL, StCntH, StCntL, StDataH, StDataL, StWrite, StCsum, StDone, StErr
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [15:0]         count_q, count_d;
  logic [7:0]          chk_q, chk_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic                in_frame;
  logic [7:0]          sum;

  assign accept   = rx_valid && (state_q != StWrite);
  assign sum      = chk_q + rx_data;
  // States that are waiting on a frame byte and therefore subject to timeout.
  assign in_frame = !(state_q inside {StIdle, StWrite, StDone, StErr});

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      word_q  <= '0;
      count_q <= '0;
      chk_q   <= '0;
      timer_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      count_q <= count_d;
      chk_q   <= chk_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // Frame parser next-state logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    count_d = count_q;
    chk_d   = chk_q;
    timer_d = '0;
    hold_d  = hold_q;
    done_d  = done_q;
    error_d = error_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        state_d = StIdle;
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d = StAddrH;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          chk_d   = '0;
        end
      end
      StAddrH: if (accept) begin
        addr_d  = ADDR_W'({rx_data[4:0], 8'h00});
        chk_d   = sum;
        state_d = StAddrL;
      end
      StAddrL: if (accept) begin
        addr_d  = addr_q | ADDR_W'(rx_data);
        chk_d   = sum;
        state_d = StCntH;
      end
      StCntH: if (accept) begin
        count_d = {rx_data, 8'h00};
        chk_d   = sum;
        state_d = StCntL;
      end
      StCntL: if (accept) begin
        count_d = {count_q[15:8], rx_data};
        chk_d   = sum;
        state_d = (count_d == 16'd0) ? StCsum : StDataH;
      end
      StDataH: if (accept) begin
        chk_d = sum;
        if (rx_data[7:6] != 2'b00) begin
          state_d = StErr;
          error_d = 1'b1;
        end else begin
          word_d  = DATA_W'({rx_data[5:0], 8'h00});
          state_d = StDataL;
        end
      end
      StDataL: if (accept) begin
        word_d  = word_q | DATA_W'(rx_data);
        chk_d   = sum;
        state_d = StWrite;
      end
      StWrite: begin
        // Write issues this cycle; step to the next word (address wraps).
        addr_d  = addr_q + 1'b1;
        count_d = count_q - 16'd1;
        state_d = (count_q == 16'd1) ? StCsum : StDataH;
      end
      StCsum: if (accept) begin
        chk_d = sum;
        if (sum == 8'h00) begin
          state_d = StDone;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = StErr;
          error_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Inter-byte idle timer; accepted bytes leave it cleared.
    if (in_frame && !accept) begin
      if (timer_q == TimerMax) begin
        state_d = StErr;
        error_d = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // Outputs; reset forces reset values in the same cycle and kills a pending write.
  always_comb begin
    rx_ready  = reset || (state_q != StWrite);
    mem_we    = !reset && (state_q == StWrite);
    mem_addr  = reset ? '0 : addr_q;
    mem_wdata = reset ? '0 : word_q;
    core_hold = reset || hold_q;
    done      = !reset && done_q;
    error     = !reset && error_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed frames from the test plan plus random frames;
// a frame-level model fills write/outcome queues that a monitor drains.
module tb_prog_loader;

  localparam int unsigned To = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [13:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  prog_loader #(
    .ADDR_W   (13),
    .DATA_W   (14),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (To)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .core_hold(core_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [26:0] exp_wr[$];   // {addr, data}
  logic [1:0]  exp_out[$];  // {done, error}
  logic [7:0]  frame[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Monitor: drains expectations whenever the DUT writes or finishes a frame.
  logic        prev_done = 1'b0;
  logic        prev_err  = 1'b0;
  logic [26:0] ew;
  logic [1:0]  eo;
  always @(negedge clk) begin
    #2;
    if (mem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 mem_addr, mem_wdata);
      end else begin
        ew = exp_wr.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(ew[26:14]));
        check("wr_data", 32'(mem_wdata), 32'(ew[13:0]));
      end
    end
    if ((done === 1'b1 && !prev_done) || (error === 1'b1 && !prev_err)) begin
      if (exp_out.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_outcome: got done=%0b error=%0b expected none", done, error);
      end else begin
        eo = exp_out.pop_front();
        check("out_done", 32'(done), 32'(eo[1]));
        check("out_error", 32'(error), 32'(eo[0]));
        check("out_core_hold", 32'(core_hold), 32'(!eo[1]));
      end
    end
    prev_done = (done === 1'b1);
    prev_err  = (error === 1'b1);
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL rx_stall: got rx_ready=0 for 50 cycles expected 1");
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input int unsigned gap_max);
    foreach (frame[i]) send_byte(frame[i], $urandom_range(0, gap_max));
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Builds a frame; bad_at >= 0 replaces that word's HI byte with an illegal one
  // and truncates the frame there.
  task automatic build_frame(input logic [12:0] addr, input logic [2:0] junk,
                             input logic [13:0] words[$], input bit good, input int bad_at);
    logic [7:0] s;
    logic [7:0] cs;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back({junk, addr[12:8]});
    frame.push_back(addr[7:0]);
    frame.push_back(8'(words.size() >> 8));
    frame.push_back(8'(words.size()));
    foreach (words[i]) begin
      if (i == bad_at) begin
        frame.push_back({2'($urandom_range(1, 3)), 6'($urandom)});
        return;
      end
      frame.push_back({2'b00, words[i][13:8]});
      frame.push_back(words[i][7:0]);
    end
    s = 8'h00;
    for (int i = 1; i < frame.size(); i++) s = s + frame[i];
    cs = 8'h00 - s;
    if (!good) cs = cs + 8'h01;
    frame.push_back(cs);
  endtask

  // Reference model: interpret the frame bytes directly.
  task automatic model_frame();
    logic [12:0] a;
    logic [7:0]  hi;
    logic [7:0]  s;
    int unsigned cnt;
    int          idx;
    a   = {frame[1][4:0], frame[2]};
    cnt = {frame[3], frame[4]};
    idx = 5;
    for (int i = 0; i < int'(cnt); i++) begin
      hi = frame[idx];
      if (hi[7:6] != 2'b00) begin
        exp_out.push_back(2'b01);
        return;
      end
      exp_wr.push_back({a, hi[5:0], frame[idx + 1]});
      a   = a + 13'd1;
      idx = idx + 2;
    end
    s = 8'h00;
    for (int i = 1; i < frame.size(); i++) s = s + frame[i];
    exp_out.push_back((s == 8'h00) ? 2'b10 : 2'b01);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  logic [13:0] w[$];
  logic [7:0]  junk_b;
  logic [12:0] ra;
  int          bad;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check_reset_vals("reset");

    // Good frame at 0x010.
    w = '{14'h3FFF, 14'h1234};
    build_frame(13'h010, 3'b000, w, 1'b1, -1);
    model_frame();
    send_frame(0);
    #1;
    check("good_done", 32'(done), 32'd1);
    check("good_core_hold", 32'(core_hold), 32'd0);
    check("good_error", 32'(error), 32'd0);

    // Same frame, checksum off by one.
    build_frame(13'h010, 3'b000, w, 1'b0, -1);
    model_frame();
    send_frame(1);
    #1;
    check("badcs_core_hold", 32'(core_hold), 32'd1);

    // Illegal HI byte, then a stray byte in idle.
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0};
    model_frame();
    send_frame(0);
    send_byte(8'h12, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Address wrap and zero count.
    w = '{14'h0ABC, 14'h2DEF};
    build_frame(13'h1FFF, 3'b101, w, 1'b1, -1);
    model_frame();
    send_frame(2);
    w.delete();
    build_frame(13'h0123, 3'b000, w, 1'b1, -1);
    model_frame();
    send_frame(0);

    // Timeout after two bytes, then a good frame.
    frame = '{8'hA5, 8'h00};
    exp_out.push_back(2'b01);
    send_frame(0);
    repeat (2 * To + 4) @(negedge clk);
    w = '{14'h0001, 14'h0002, 14'h0003};
    build_frame(13'h0100, 3'b000, w, 1'b1, -1);
    model_frame();
    send_frame(3);

    // Random frames with random gaps, junk and mid-frame sync bytes.
    for (int f = 0; f < 40; f++) begin
      w.delete();
      repeat ($urandom_range(0, 4)) w.push_back(14'($urandom));
      ra = 13'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 13'h1FFE + 13'($urandom_range(0, 1));
      bad = ($urandom_range(0, 7) == 0 && w.size() > 0) ? int'($urandom_range(0, w.size() - 1)) : -1;
      build_frame(ra, 3'($urandom), w, ($urandom_range(0, 3) != 0), bad);
      model_frame();
      send_frame(3);
      if ($urandom_range(0, 1) == 1) begin
        junk_b = 8'($urandom);
        if (junk_b == 8'hA5) junk_b = 8'h00;
        send_byte(junk_b, 0);
        @(negedge clk);
        rx_valid = 1'b0;
      end
    end

    // Reset during the write cycle of word 2.
    w = '{14'h3FFF, 14'h1234};
    build_frame(13'h010, 3'b000, w, 1'b1, -1);
    exp_wr.push_back({13'h010, 14'h3FFF});
    for (int i = 0; i < 9; i++) send_byte(frame[i], 0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_reset_vals("rst_write");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals("post_rst");

    // Recovery after reset.
    build_frame(13'h0777, 3'b000, w, 1'b1, -1);
    model_frame();
    send_frame(1);

    repeat (5) @(negedge clk);
    check("writes_left", 32'(exp_wr.size()), 32'd0);
    check("outcomes_left", 32'(exp_out.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
